// File: rtl/reg_file_mp.sv
//------------------------------------------------------------------------------
// reg_file_mp : multi-read-port register file with a hardwired zero register
//               and a post-reset clear sweep. The macro REG_FILE_BYPASS_EN
//               enables a same-cycle write-through bypass on each read port.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module reg_file_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 31
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] ra,
    output logic [NUM_RD*DATA_W-1:0] rd,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        wa,
    input  logic [DATA_W-1:0]        wd,
    output logic                     ready
);

    localparam int                c_depth    = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] c_zero     = ADDR_W'(ZERO_REG);
    localparam logic [ADDR_W:0]   c_last_idx = (ADDR_W + 1)'(c_depth - 1);

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W:0]     r_clr_cnt;
    logic [ADDR_W:0]     w_clr_cnt_nxt;
    logic                w_clr_we;
    logic                w_wr_en;
    logic [DATA_W-1:0]   r_mem [c_depth];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= CLEAR;
            r_clr_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_cnt <= w_clr_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_clr_cnt_nxt = r_clr_cnt;
        w_clr_we      = 1'b0;
        case (r_state)
            CLEAR: begin
                w_clr_we      = 1'b1;
                w_clr_cnt_nxt = r_clr_cnt + (ADDR_W + 1)'(1);
                if (r_clr_cnt == c_last_idx) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                w_state_nxt = RUN;
            end
            default: begin
                w_state_nxt = CLEAR;
            end
        endcase
    end

    assign ready   = (r_state == RUN);
    assign w_wr_en = ready && we && (wa != c_zero);

    // Storage has no reset; the sweep is what brings it to a known state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (w_clr_we) begin
                r_mem[r_clr_cnt[ADDR_W-1:0]] <= '0;
            end else if (w_wr_en) begin
                r_mem[wa] <= wd;
            end
        end
    end

    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
        logic [ADDR_W-1:0] w_ra;
        logic [DATA_W-1:0] w_data;

        assign w_ra = ra[gi*ADDR_W +: ADDR_W];

        always_comb begin
            w_data = r_mem[w_ra];
`ifdef REG_FILE_BYPASS_EN
            if (w_wr_en && (wa == w_ra)) begin
                w_data = wd;
            end
`endif
            // Masking while not ready keeps uninitialised storage off the bus.
            if (!ready || (w_ra == c_zero)) begin
                w_data = '0;
            end
        end

        assign rd[gi*DATA_W +: DATA_W] = w_data;
    end

endmodule

`default_nettype wire

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
- Parametrised multi-read-port register file for the Beta datapath and its successors.
- Generalises the 32x32, 2-read/1-write register file in data width, address width and read-port count.
- Adds a hardwired zero register at a configurable index and a post-reset clear sweep that zeroes every entry. A `ready` flag gates use until the sweep is done.
- Sits between the decode stage (read ports) and the write-back stage (write port).

Parameters:
- DATA_W, 32, register data width in bits.
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries.
- NUM_RD, 2, number of independent asynchronous read ports (1..4).
- ZERO_REG, 31, index of the hardwired zero register: reads 0, writes discarded. Must be < DEPTH.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- ra  in  NUM_RD*ADDR_W  packed read addresses; port i occupies bits [i*ADDR_W +: ADDR_W].
- rd  out  NUM_RD*DATA_W  packed read data; port i occupies bits [i*DATA_W +: DATA_W].
- we  in  1  write enable.
- wa  in  ADDR_W  write address.
- wd  in  DATA_W  write data.
- ready  out  1  high once the clear sweep has completed; low during reset and the sweep.

Behaviour:
- Storage: DEPTH x DATA_W array. Sweep counter clr_cnt is ADDR_W+1 bits wide.
- State machine: two states, CLEAR and RUN.
  - On a clock edge with rst=1: state=CLEAR, clr_cnt=0, ready=0. Array contents are not reset directly.
  - CLEAR, rst=0: each cycle writes 0 to mem[clr_cnt[ADDR_W-1:0]] and increments clr_cnt.
  - When clr_cnt reaches DEPTH-1 and that entry is written, the next state is RUN and ready=1.
  - The sweep therefore takes exactly DEPTH cycles after rst falls; ready rises on the DEPTH-th edge after rst deasserts.
  - RUN: stays in RUN until rst. rst asserted mid-RUN or mid-CLEAR restarts the sweep from entry 0 on the next edge.
- Reads:
  - Combinational, zero latency: rd[i] = mem[ra[i]].
  - rd[i] is forced to 0 when ra[i] == ZERO_REG.
  - rd[i] is forced to 0 while ready=0, independent of array contents, so X never propagates.
- Writes:
  - In RUN, when we=1 and wa != ZERO_REG, mem[wa] <= wd on the rising edge.
  - Without bypass, the new value is visible on reads in the following cycle. A same-cycle read of wa returns the old value.
  - In CLEAR, we is ignored: no write, no buffering, no error flag.
  - A write to ZERO_REG is silently discarded.
- Multiple read ports addressing the same entry return identical data.
- Widths: no arithmetic on data. Addresses are used unsigned, with no wrap or range check needed, since DEPTH covers the full ADDR_W space.
- Reset values: ready=0 and state=CLEAR. rd outputs read 0 during reset and the sweep.

Optional Feature:
- Macro: REG_FILE_BYPASS_EN.
- Defined: write-through bypass. For each port i, if ready=1, we=1, wa == ra[i] and wa != ZERO_REG, then rd[i]=wd in the same cycle. This removes the write-back to decode hazard.
- Not defined: reads always return array contents, i.e. the old value during a same-cycle write.
- Both builds: bypass never applies during CLEAR or to ZERO_REG.

Test Plan:
- Reset sweep: assert rst 2 cycles, then release. Required: ready=0 for exactly 32 edges and high on the 32nd; all rd=0 throughout. Afterwards, reading each of entries 0..30 returns 0x00000000.
- Basic write/read: in RUN, write 0xDEADBEEF to r5. Next cycle ra={r5,r5} gives both rd=0xDEADBEEF. Write 0x12345678 to r7; port 0=r5 and port 1=r7 give the respective values.
- Zero register: write 0xFFFFFFFF to r31, then read r31 on all ports. Required: 0x00000000; r30 is unchanged.
- Write during CLEAR: pulse rst, then drive we=1, wa=3, wd=0xA5A5A5A5 during the sweep. After ready rises, r3 reads 0.
- Reset mid-operation: write 0x55 to r9 in RUN, assert rst for 1 cycle, then release. Required: ready drops on the next edge and returns 32 edges after release; r9 reads 0.
- Same-cycle read/write: we=1, wa=4, wd=0x0BADF00D with ra[0]=4, and r4 previously 0x11. Required: rd[0]=0x0BADF00D with REG_FILE_BYPASS_EN defined, 0x11 without it; both builds read 0x0BADF00D the next cycle.
